// File: rtl/neuron_mac_stage.sv
// neuron_mac_stage
//   Multiply-accumulate stage for one neuron's weighted sum in Q8.8 fixed
//   point. It accepts a neuron command, then a stream of input/weight pairs.
//   It rounds toward -inf and saturates the sum, issues a one-cycle write
//   pulse to the activation stage, and then waits for that stage's
//   finished-neuron pulse.
//
// Parameters
//   FRAC   fractional bits of inputs, weights, bias and result (Q8.8)
//   ACC_W  signed accumulator width; 40 bits holds 255 Q16.16 products plus
//          the aligned bias without wrapping
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   start           neuron command valid (sampled only in IDLE)
//   termCount       number of input/weight pairs (0..255)
//   bias            signed Q8.8 bias
//   destIn, selIn   destination address / activation select, latched on start
//   xVal, wVal      signed Q8.8 input and weight
//   termValid       pair valid
//   termReady       pair accepted when termValid && termReady
//   outVal          saturated Q8.8 sum
//   outDest, actSel latched destination / activation select
//   outWE           one-cycle write pulse to the activation stage
//   actDone         finished-neuron pulse from the activation stage
//   busy            high in every state except IDLE
module neuron_mac_stage #(
  parameter int FRAC  = 8,
  parameter int ACC_W = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         termCount,
  input  logic signed [15:0] bias,
  input  logic [15:0]        destIn,
  input  logic [1:0]         selIn,
  input  logic signed [15:0] xVal,
  input  logic signed [15:0] wVal,
  input  logic               termValid,
  output logic               termReady,
  output logic signed [15:0] outVal,
  output logic [15:0]        outDest,
  output logic [1:0]         actSel,
  output logic               outWE,
  input  logic               actDone,
  output logic               busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ACCUM    = 3'd1,
    ROUND    = 3'd2,
    WRITE    = 3'd3,
    WAIT_ACT = 3'd4
  } state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(32768);

  state_t                   state;
  logic signed [ACC_W-1:0]  acc;
  logic [7:0]               remaining;
  logic signed [31:0]       product;

  // Drop the extra FRAC fraction bits of the Q16.16 accumulator with an
  // arithmetic shift (truncation toward -inf), then clamp to the Q8.8 range.
  function automatic logic signed [15:0] round_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] r;
    r = a >>> FRAC;
    if (r > SAT_MAX)
      return 16'sh7fff;
    else if (r < SAT_MIN)
      return -16'sh8000;
    else
      return r[15:0];
  endfunction

  // Full-precision Q8.8 x Q8.8 -> Q16.16 product.
  assign product = xVal * wVal;

  assign termReady = (state == ACCUM);
  assign outWE     = (state == WRITE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      outVal    <= '0;
      outDest   <= '0;
      actSel    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            outDest   <= destIn;
            actSel    <= selIn;
            remaining <= termCount;
            // Align the Q8.8 bias to the Q16.16 accumulator.
            acc       <= ACC_W'(bias) <<< FRAC;
            state     <= (termCount == 8'd0) ? ROUND : ACCUM;
          end
        end
        ACCUM: begin
          if (termValid) begin
            acc       <= acc + ACC_W'(product);
            remaining <= remaining - 8'd1;
            if (remaining == 8'd1) state <= ROUND;
          end
        end
        ROUND: begin
          outVal <= round_sat(acc);
          state  <= WRITE;
        end
        WRITE: begin
          state <= WAIT_ACT;
        end
        WAIT_ACT: begin
          // A start that arrives with actDone is dropped: only IDLE samples it.
          if (actDone) state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_stage.sv
// tb_neuron_mac_stage
//   Directed scoreboard bench for neuron_mac_stage. Each neuron command
//   pushes its hand-computed result onto a queue. A monitor pops the queue
//   and compares whenever outWE is seen.
module tb_neuron_mac_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  termCount = '0;
  logic [15:0] bias = '0;
  logic [15:0] destIn = '0;
  logic [1:0]  selIn = '0;
  logic [15:0] xVal = '0;
  logic [15:0] wVal = '0;
  logic        termValid = 1'b0;
  logic        actDone = 1'b0;
  logic        termReady;
  logic [15:0] outVal;
  logic [15:0] outDest;
  logic [1:0]  actSel;
  logic        outWE;
  logic        busy;

  typedef struct packed {
    logic [15:0] val;
    logic [15:0] dest;
    logic [1:0]  sel;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          passes = 0;
  longint      cyc = 0;
  logic        prev_we = 1'b0;
  logic [15:0] xs[8];
  logic [15:0] ws[8];

  neuron_mac_stage #(.FRAC(8), .ACC_W(40)) dut (
    .clk(clk), .rst(rst), .start(start), .termCount(termCount), .bias(bias),
    .destIn(destIn), .selIn(selIn), .xVal(xVal), .wVal(wVal),
    .termValid(termValid), .termReady(termReady), .outVal(outVal),
    .outDest(outDest), .actSel(actSel), .outWE(outWE), .actDone(actDone),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    $display("FAIL %s: got no response within the cycle budget, expected one", name);
  endtask

  // Monitor: compare every write pulse against the oldest expected result.
  always @(negedge clk) begin
    if (!rst && outWE) begin
      check("we_single_cycle", 32'(prev_we), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_we: got outWE=1 outVal=0x%0h, expected no write", outVal);
      end else begin
        mon_e = exp_q.pop_front();
        check("outVal", 32'(outVal), 32'(mon_e.val));
        check("outDest", 32'(outDest), 32'(mon_e.dest));
        check("actSel", 32'(actSel), 32'(mon_e.sel));
      end
    end
    prev_we <= rst ? 1'b0 : outWE;
  end

  // Issue one neuron (pairs from xs/ws), play the activation stage, and
  // return in the first IDLE cycle (at #1 after the edge).
  task automatic run_neuron(input logic [15:0] b, input int n, input logic [15:0] dest,
                            input logic [1:0] sel, input int gap, input int act_delay,
                            input bit act_in_write, input bit start_in_wait,
                            input logic [15:0] expv);
    int     guard;
    bit     tr;
    bit     tr_seen;
    longint c0;
    check("idle_before_start", 32'(busy), 32'd0);
    exp_q.push_back({expv, dest, sel});
    bias = b; termCount = n[7:0]; destIn = dest; selIn = sel; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; c0 = cyc;
    // Scramble command inputs to prove they were latched.
    bias = 16'h5a5a; destIn = 16'hbeef; selIn = ~sel; termCount = 8'hff;
    check("busy_after_start", 32'(busy), 32'd1);
    if (n > 0) check("ready_after_start", 32'(termReady), 32'd1);
    for (int i = 0; i < n; i++) begin
      if (gap > 0 && i > 0) begin
        termValid = 1'b0; xVal = 16'h7fff; wVal = 16'h7fff;
        repeat (gap) begin @(posedge clk); #1; end
      end
      termValid = 1'b1; xVal = xs[i]; wVal = ws[i];
      guard = 0;
      do begin
        @(negedge clk); tr = termReady;
        @(posedge clk); #1; guard++;
      end while (!tr && guard < 50);
      if (!tr) timeout_fail("term_accept");
    end
    // Junk pair held valid outside ACCUM must be ignored.
    termValid = 1'b1; xVal = 16'h7fff; wVal = 16'h7fff;
    tr_seen = 1'b0; guard = 0;
    while (!outWE && guard < 100) begin
      if (termReady) tr_seen = 1'b1;
      @(posedge clk); #1; guard++;
    end
    termValid = 1'b0;
    if (!outWE) begin
      timeout_fail("write_pulse");
    end else begin
      if (gap == 0) check("latency", 32'(cyc - c0), 32'(n + 1));
      if (n == 0) check("no_ready_zero_terms", 32'(tr_seen), 32'd0);
    end
    if (act_in_write) actDone = 1'b1;
    @(posedge clk); #1;
    actDone = 1'b0;
    for (int d = 0; d < act_delay; d++) begin
      check("busy_in_wait", 32'(busy), 32'd1);
      if (start_in_wait && d == act_delay / 2) begin
        start = 1'b1; destIn = 16'hdead; termCount = 8'd0;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("busy_before_done", 32'(busy), 32'd1);
    actDone = 1'b1;
    if (start_in_wait) begin start = 1'b1; destIn = 16'hdead; termCount = 8'd0; end
    @(posedge clk); #1;
    actDone = 1'b0; start = 1'b0;
    check("idle_after_done", 32'(busy), 32'd0);
    check("dest_held", 32'(outDest), 32'(dest));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk); #1;
    check("rst_outVal", 32'(outVal), 32'd0);
    check("rst_outDest", 32'(outDest), 32'd0);
    check("rst_actSel", 32'(actSel), 32'd0);
    check("rst_outWE", 32'(outWE), 32'd0);
    check("rst_termReady", 32'(termReady), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single term: 0.5 + 2.0*1.5 = 3.5
    xs[0] = 16'h0200; ws[0] = 16'h0180;
    run_neuron(16'h0080, 1, 16'h0101, 2'd1, 0, 0, 1'b0, 1'b0, 16'h0380);
    // Zero terms: bias only
    run_neuron(16'h1234, 0, 16'h0202, 2'd2, 0, 0, 1'b0, 1'b0, 16'h1234);
    // Positive saturation
    for (int i = 0; i < 4; i++) begin xs[i] = 16'h7fff; ws[i] = 16'h7fff; end
    run_neuron(16'h0000, 4, 16'h0303, 2'd3, 0, 0, 1'b0, 1'b0, 16'h7fff);
    // Negative saturation
    for (int i = 0; i < 4; i++) begin xs[i] = 16'h8000; ws[i] = 16'h7fff; end
    run_neuron(16'h0000, 4, 16'h0404, 2'd0, 0, 0, 1'b0, 1'b0, 16'h8000);
    // Tiny negative product truncates toward -inf
    xs[0] = 16'h0001; ws[0] = 16'hffff;
    run_neuron(16'h0000, 1, 16'h0505, 2'd1, 0, 0, 1'b0, 1'b0, 16'hffff);
    // N=3: 0.25 + 1*3 + 2*0.5 + (-1)*1 = 3.25, without and with gaps
    xs[0] = 16'h0100; ws[0] = 16'h0300;
    xs[1] = 16'h0200; ws[1] = 16'h0080;
    xs[2] = 16'hff00; ws[2] = 16'h0100;
    run_neuron(16'h0040, 3, 16'h0606, 2'd2, 0, 0, 1'b0, 1'b0, 16'h0340);
    run_neuron(16'h0040, 3, 16'h0707, 2'd2, 2, 0, 1'b0, 1'b0, 16'h0340);
    // actDone withheld 10 cycles, starts during the wait and alongside actDone
    xs[0] = 16'h0200; ws[0] = 16'h0180;
    run_neuron(16'h0080, 1, 16'h0808, 2'd3, 0, 10, 1'b0, 1'b1, 16'h0380);
    // actDone pulse during WRITE is ignored
    run_neuron(16'h0080, 1, 16'h0909, 2'd0, 0, 3, 1'b1, 1'b0, 16'h0380);
    // Back-to-back: second start in the first idle cycle
    xs[0] = 16'h0100; ws[0] = 16'h0100;
    run_neuron(16'h0000, 1, 16'haaaa, 2'd1, 0, 0, 1'b0, 1'b0, 16'h0100);
    xs[0] = 16'h0080; ws[0] = 16'h0080;
    run_neuron(16'hff00, 1, 16'h5555, 2'd2, 0, 0, 1'b0, 1'b0, 16'hff40);

    // Reset after 2 of 5 terms
    bias = 16'h0100; termCount = 8'd5; destIn = 16'h7777; selIn = 2'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    termValid = 1'b1; xVal = 16'h0100; wVal = 16'h0100;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_outVal", 32'(outVal), 32'd0);
    check("midrst_outDest", 32'(outDest), 32'd0);
    check("midrst_actSel", 32'(actSel), 32'd0);
    check("midrst_outWE", 32'(outWE), 32'd0);
    check("midrst_termReady", 32'(termReady), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    termValid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    // Fresh neuron: 1*3 = 3, no residue from the aborted sum
    xs[0] = 16'h0100; ws[0] = 16'h0300;
    run_neuron(16'h0000, 1, 16'h0c0c, 2'd1, 0, 0, 1'b0, 1'b0, 16'h0300);

    repeat (5) @(posedge clk); #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/neuron_mac_stage.md
# neuron_mac_stage

Multiply-accumulate stage that computes one neuron's weighted sum in Q8.8 fixed point. It sits directly upstream of the activation-function stage. It accepts a neuron command (bias, term count, destination, activation select) and then a stream of input/weight pairs. It delivers the saturated 16-bit sum with a one-cycle write pulse, then holds until the activation stage reports completion through its finished-neuron signal.

## Interface
- FRAC, 8, fractional bits of the Q format for inputs, weights, bias and result.
- ACC_W, 40, accumulator width in bits, signed; must be ≥ 32 + 8.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  neuron command valid; sampled only in IDLE.
- termCount  in  8  number of input/weight pairs for this neuron (0–255).
- bias  in  16  signed Q8.8 bias.
- destIn  in  16  destination address; latched on start.
- selIn  in  2  activation select; latched on start.
- xVal  in  16  signed Q8.8 input value.
- wVal  in  16  signed Q8.8 weight.
- termValid  in  1  xVal/wVal pair valid.
- termReady  out  1  pair accepted on an edge where termValid && termReady.
- outVal  out  16  saturated Q8.8 sum, drives the activation stage data input.
- outDest  out  16  latched destIn.
- actSel  out  2  latched selIn.
- outWE  out  1  one-cycle write pulse to the activation stage.
- actDone  in  1  finished-neuron pulse from the activation stage.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ACCUM, ROUND, WRITE, WAIT_ACT.
- IDLE + start:
  - latch destIn, selIn and termCount into the remaining-term counter;
  - load acc ← sign-extend(bias) <<< FRAC;
  - go to ACCUM, or to ROUND if termCount == 0.
- ACCUM:
  - termReady = 1;
  - each accepted pair does acc ← acc + sext(xVal × wVal), a 32-bit signed Q16.16 product, and decrements the counter;
  - on the edge accepting the last pair, go to ROUND;
  - cycles with termValid low stall without limit.
- ROUND:
  - r = acc >>> FRAC (arithmetic shift, truncation toward −∞);
  - outVal ← r clamped to [−32768, 32767] (0x8000..0x7FFF);
  - go to WRITE.
- WRITE: outWE = 1 (decoded from state); unconditionally go to WAIT_ACT.
- WAIT_ACT: on actDone = 1 go to IDLE; otherwise hold.
- actDone is ignored in every state except WAIT_ACT.
- start is ignored while busy; xVal, wVal and termValid are ignored outside ACCUM.
- termReady = 0 outside ACCUM.
- outVal, outDest and actSel hold their values until the next ROUND or start, so they stay stable through the activation stage capture.
- The accumulator never wraps for 255 terms plus bias at ACC_W = 40. Saturation is applied only at ROUND.

## Timing
- Reset values:
  - state IDLE;
  - outVal 0x0000, outDest 0x0000, actSel 0;
  - outWE, termReady and busy 0;
  - acc and counter 0.
- Reset is effective immediately, including mid-ACCUM or in WAIT_ACT. The partial sum is discarded and no outWE is issued.
- busy rises in the cycle after the start edge.
- termReady is high from the cycle after the start edge until the edge that accepts the last pair.
- Latency with N ≥ 1 terms and no stalls:
  - start edge E0;
  - pairs accepted on E1..EN;
  - ROUND state in cycle N+1, outVal registered on edge EN+1;
  - outWE high during cycle N+2;
  - WAIT_ACT from EN+2.
- Latency with N = 0: ROUND after E0, outVal registered on E1, outWE high in the cycle after E1.
- The activation stage captures on the outWE cycle and returns actDone one cycle later. Minimum return to IDLE is therefore edge EN+3, and a new start is accepted on EN+4.
- Simultaneous start and actDone in WAIT_ACT: go to IDLE only; that start is not accepted.

## Test plan
- Single term: bias 0x0080, start, N=1, x 0x0200, w 0x0180 → outVal 0x0380; outWE exactly one cycle; outDest and actSel equal the latched values.
- Zero terms: bias 0x1234, N=0 → outVal 0x1234 on edge E1; outWE in the following cycle; termReady never asserted.
- Saturation and sign:
  - four terms of x = w = 0x7FFF, bias 0 → outVal 0x7FFF;
  - four terms of x 0x8000, w 0x7FFF → outVal 0x8000;
  - x 0x0001, w 0xFFFF → outVal 0xFFFF (truncation toward −∞).
- Handshake:
  - N=3 with termValid gaps of 2 cycles → result identical to the no-gap run;
  - actDone withheld 10 cycles → busy stays high and a start during the wait is ignored;
  - actDone pulse during WRITE is ignored.
- Back-to-back: two neurons, second start issued on the first cycle busy is low → both results correct; second outDest differs from first.
- Reset: assert rst after 2 of 5 terms → all outputs return to reset values immediately; a following N=1 neuron produces the correct fresh sum with no residue.
